// File: rtl/gcd_lcm_pkg.sv
// rtl/gcd_lcm_pkg.sv - state codes and opcode constants shared by the GCD/LCM unit
package gcd_lcm_pkg;

  typedef logic [2:0] state_t;

  localparam state_t IDLE  = 3'd0;
  localparam state_t ALIGN = 3'd1;
  localparam state_t LOOP  = 3'd2;
  localparam state_t DIV   = 3'd3;
  localparam state_t MUL   = 3'd4;
  localparam state_t DONE  = 3'd5;

  localparam logic OP_GCD = 1'b0;
  localparam logic OP_LCM = 1'b1;

endpackage

// File: rtl/seq_divmul.sv
// rtl/seq_divmul.sv - WIDTH-cycle restoring divide followed by WIDTH-cycle shift-add multiply
// One {hi,lo} shift pair serves both phases: the quotient left in lo becomes the multiplier.
module seq_divmul #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   multiplicand,
  output logic               div_last,
  output logic               mul_last,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic             active_q, active_d;
  logic             mul_q, mul_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] div_hi, div_lo, mul_hi, mul_lo;
  logic             last;

  always_comb begin
    // Partial remainder stays below the divisor, so a borrow shows up in the top bit.
    trial = {hi_q, lo_q[WIDTH-1]} - {1'b0, dsr_q};
    if (trial[WIDTH]) begin
      div_hi = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
      div_lo = {lo_q[WIDTH-2:0], 1'b0};
    end else begin
      div_hi = trial[WIDTH-1:0];
      div_lo = {lo_q[WIDTH-2:0], 1'b1};
    end

    sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    mul_hi = sum[WIDTH:1];
    mul_lo = {sum[0], lo_q[WIDTH-1:1]};

    last     = active_q && (cnt_q == LAST);
    div_last = last && !mul_q;
    mul_last = last && mul_q;
    product  = {mul_hi, mul_lo};
  end

  always_comb begin
    active_d = active_q;
    mul_d    = mul_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dsr_d    = dsr_q;
    mcand_d  = mcand_q;
    if (start) begin
      active_d = 1'b1;
      mul_d    = 1'b0;
      cnt_d    = '0;
      hi_d     = '0;
      lo_d     = dividend;
      dsr_d    = divisor;
      mcand_d  = multiplicand;
    end else if (active_q) begin
      cnt_d = cnt_q + 1'b1;
      if (!mul_q) begin
        hi_d = div_hi;
        lo_d = div_lo;
        if (last) begin
          mul_d = 1'b1;
          hi_d  = '0;
          cnt_d = '0;
        end
      end else begin
        hi_d = mul_hi;
        lo_d = mul_lo;
        if (last) begin
          active_d = 1'b0;
          cnt_d    = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      mul_q    <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dsr_q    <= '0;
      mcand_q  <= '0;
    end else begin
      active_q <= active_d;
      mul_q    <= mul_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dsr_q    <= dsr_d;
      mcand_q  <= mcand_d;
    end
  end

endmodule

// File: rtl/gcd_lcm_unit.sv
// rtl/gcd_lcm_unit.sv - multi-cycle binary-GCD / LCM coprocessor with busy/done handshake
module gcd_lcm_unit
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_lcm,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int K_W = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0]   g;
  logic               div_start, div_last, mul_last;
  logic [2*WIDTH-1:0] product;

  assign g = v_q << k_q;

  seq_divmul #(.WIDTH(WIDTH)) u_divmul (
    .clk          (clk),
    .reset        (reset),
    .start        (div_start),
    .dividend     (a_q),
    .divisor      (g),
    .multiplicand (b_q),
    .div_last     (div_last),
    .mul_last     (mul_last),
    .product      (product)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    u_d        = u_q;
    v_d        = v_q;
    k_d        = k_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    div_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op_lcm;
          a_d  = a;
          b_d  = b;
          u_d  = a;
          v_d  = b;
          k_d  = '0;
          if ((a == '0) || (b == '0)) begin
            result_d   = (op_lcm == OP_LCM) ? '0 : (a | b);
            overflow_d = 1'b0;
            state_d    = DONE;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (!u_q[0] && !v_q[0]) begin
          u_d = u_q >> 1;
          v_d = v_q >> 1;
          k_d = k_q + 1'b1;
        end else begin
          state_d = LOOP;
        end
      end
      LOOP: begin
        if (u_q == '0) begin
          if (op_q == OP_LCM) begin
            div_start = 1'b1;
            state_d   = DIV;
          end else begin
            result_d   = g;
            overflow_d = 1'b0;
            state_d    = DONE;
          end
        end else if (!u_q[0]) begin
          u_d = u_q >> 1;
        end else if (!v_q[0]) begin
          v_d = v_q >> 1;
        end else if (u_q >= v_q) begin
          u_d = u_q - v_q;
        end else begin
          v_d = v_q - u_q;
        end
      end
      DIV: begin
        if (div_last) state_d = MUL;
      end
      MUL: begin
        if (mul_last) begin
          result_d   = product[WIDTH-1:0];
          overflow_d = |product[2*WIDTH-1:WIDTH];
          state_d    = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_GCD;
      a_q        <= '0;
      b_q        <= '0;
      u_q        <= '0;
      v_q        <= '0;
      k_q        <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      u_q        <= u_d;
      v_q        <= v_d;
      k_q        <= k_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_gcd_lcm_unit.sv
// tb/tb_gcd_lcm_unit.sv - directed and randomized checks of gcd_lcm_unit against an arithmetic model
module tb_gcd_lcm_unit;

  localparam int W       = 32;
  localparam int GCD_MAX = 5 * W + 5;
  localparam int TIMEOUT = 400;

  logic          clk;
  logic          reset;
  logic          start;
  logic          op_lcm;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          overflow;

  int checks;
  int failures;

  gcd_lcm_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op_lcm   (op_lcm),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic longint unsigned ref_gcd(input longint unsigned x, input longint unsigned y);
    longint unsigned t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Returns {overflow, result} for the requested operation.
  function automatic logic [32:0] ref_op(input logic op, input logic [31:0] x, input logic [31:0] y);
    longint unsigned g, p;
    if (!op) return {1'b0, 32'(ref_gcd(64'(x), 64'(y)))};
    if (x == 0 || y == 0) return 33'd0;
    g = ref_gcd(64'(x), 64'(y));
    p = (64'(x) / g) * 64'(y);
    return {(p[63:32] != 0), p[31:0]};
  endfunction

  // Issues one operation and returns the observed result plus the start->done cycle count
  // (start cycle and done cycle both included). inject_at > 0 fires a stray start while busy.
  task automatic run_op(input logic op, input logic [31:0] ia, input logic [31:0] ib,
                        input int inject_at, output logic [31:0] res, output logic ovf,
                        output int cyc, output logic busy_ok);
    @(negedge clk);
    start  = 1'b1;
    op_lcm = op;
    a      = ia;
    b      = ib;
    @(negedge clk);
    start  = 1'b0;
    a      = $urandom;
    b      = $urandom;
    cyc     = 2;
    busy_ok = 1'b1;
    while (!done && cyc < TIMEOUT) begin
      if (!busy) busy_ok = 1'b0;
      if (cyc == inject_at) begin
        start  = 1'b1;
        op_lcm = 1'b0;
        a      = 32'd9;
        b      = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1'b1);
    check("busy_at_done", busy, 1'b0);
    res = result;
    ovf = overflow;
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("result_held", {overflow, result}, {ovf, res});
  endtask

  initial begin
    logic [31:0] res, ra, rb;
    logic        ovf, bok;
    int          cyc, cyc_g, seen, mode;
    logic [32:0] exp;

    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    op_lcm   = 1'b0;
    a        = '0;
    b        = '0;
    #1;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, 32'd0);
    check("reset_overflow", overflow, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    run_op(1'b0, 32'd48, 32'd18, 0, res, ovf, cyc, bok);
    check("gcd48_18", {ovf, res}, {1'b0, 32'd6});
    check("gcd48_18_lat", (cyc <= 67), 1'b1);

    run_op(1'b1, 32'd4, 32'd6, 0, res, ovf, cyc, bok);
    check("lcm4_6", {ovf, res}, {1'b0, 32'd12});
    check("lcm4_6_busy", bok, 1'b1);

    run_op(1'b0, 32'd0, 32'd7, 0, res, ovf, cyc, bok);
    check("gcd0_7", {ovf, res}, {1'b0, 32'd7});
    check("gcd0_7_lat", cyc, 2);
    run_op(1'b1, 32'd0, 32'd7, 0, res, ovf, cyc, bok);
    check("lcm0_7", {ovf, res}, {1'b0, 32'd0});
    check("lcm0_7_lat", cyc, 2);

    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, res, ovf, cyc, bok);
    check("lcm_ovf", {ovf, res}, {1'b1, 32'h0000_0002});

    run_op(1'b1, 32'h0001_0000, 32'h0001_0000, 0, res, ovf, cyc, bok);
    check("lcm_pow2", {ovf, res}, {1'b0, 32'h0001_0000});

    run_op(1'b1, 32'd4, 32'd6, 4, res, ovf, cyc, bok);
    check("stray_start_result", {ovf, res}, {1'b0, 32'd12});
    seen = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("stray_start_dropped", seen, 0);

    // Abandon a computation partway through the GCD loop.
    @(negedge clk);
    start  = 1'b1;
    op_lcm = 1'b1;
    a      = 32'd1000001;
    b      = 32'd999999;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_before_reset", busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midop_reset_busy", busy, 1'b0);
    check("midop_reset_result", result, 32'd0);
    check("midop_reset_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen  = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("midop_reset_no_done", seen, 0);

    for (int i = 0; i < 16; i++) begin
      mode = $urandom_range(0, 3);
      ra   = $urandom;
      rb   = $urandom;
      if (mode == 1) begin
        cyc = $urandom_range(1, 4095);
        ra  = 32'($urandom_range(1, 65535)) * 32'(cyc);
        rb  = 32'($urandom_range(1, 65535)) * 32'(cyc);
      end else if (mode == 2) begin
        cyc = $urandom_range(1, 20);
        ra  = (ra | 32'd1) << cyc;
        rb  = (rb | 32'd1) << $urandom_range(1, 20);
      end else if (mode == 3 && i % 2 == 0) begin
        rb = 32'd0;
      end

      run_op(1'b0, ra, rb, 0, res, ovf, cyc_g, bok);
      exp = ref_op(1'b0, ra, rb);
      check("rand_gcd", {ovf, res}, exp);
      run_op(1'b1, ra, rb, 0, res, ovf, cyc, bok);
      exp = ref_op(1'b1, ra, rb);
      check("rand_lcm", {ovf, res}, exp);
      if (ra == 0 || rb == 0) begin
        check("rand_zero_lat", cyc, 2);
      end else begin
        check("rand_gcd_lat", (cyc_g <= GCD_MAX), 1'b1);
        check("rand_lcm_extra", cyc - cyc_g, 2 * W);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
